// File: rtl/nova_isa_pkg.sv
// -----------------------------------------------------------------------------
// nova_isa_pkg
// Shared ISA definitions for the Nova core: opcode values, instruction field
// positions and a small predecode helper used by the fetch stage.
//   OPC_ADDI / OPC_J  : opcode values held in word[31:26]
//   *_MSB / *_LSB     : field positions of opcode, J imm26 and I-type rd/rs/imm
//   is_jump(word)     : 1 when the word is an unconditional J
// -----------------------------------------------------------------------------
package nova_isa_pkg;

    localparam logic [5:0] OPC_ADDI = 6'h10;
    localparam logic [5:0] OPC_J    = 6'h28;

    // Opcode field
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    // J-type immediate
    localparam int IMM26_MSB = 25;
    localparam int IMM26_LSB = 0;
    // I-type fields
    localparam int RD_MSB    = 25;
    localparam int RD_LSB    = 21;
    localparam int RS_MSB    = 20;
    localparam int RS_LSB    = 16;
    localparam int IMM16_MSB = 15;
    localparam int IMM16_LSB = 0;

    function automatic logic is_jump(input logic [31:0] word);
        return (word[OPC_MSB:OPC_LSB] == OPC_J);
    endfunction

endpackage : nova_isa_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Small in-order FIFO holding fetched instructions until decode takes them.
// Head data comes straight from the storage registers, so nothing fed into
// wdata_i reaches rdata_o in the same cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write wdata_i at the tail (caller guarantees !full or pop)
//   pop_i      : drop the head (caller guarantees !empty)
//   flush_i    : empty the queue; overrides push and pop
//   wdata_i    : entry to enqueue
//   rdata_o    : current head entry (meaningless when empty_o=1)
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage. A push into a full queue that is popping in the same cycle
    // overwrites the slot being released, which is exactly the old head.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else if (push_i && !flush_i && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, addresses a combinational word ROM,
// predecodes unconditional J so taken jumps cost no bubble, and queues
// {pc, instr, pred_taken} for decode over a valid/ready handshake.
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_addr       : ROM word address (the PC register)
//   imem_data       : ROM word for imem_addr, same cycle
//   redirect_valid  : flush from execute; highest priority
//   redirect_pc     : PC to restart from on redirect
//   out_valid       : queue head holds an instruction
//   out_ready       : decode takes the head this cycle
//   out_instr       : head word (0 when !out_valid)
//   out_pc          : head word address (0 when !out_valid)
//   out_pred_taken  : head is a J already followed (0 when !out_valid)
// -----------------------------------------------------------------------------
module fetch_unit
    import nova_isa_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_pred_taken
);

    localparam int ENTRY_W = ADDR_W + 32 + 1;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               is_j;
    logic [ADDR_W-1:0]  j_target;
    logic               pop;
    logic               push_ok;
    logic               push;
    logic               q_full;
    logic               q_empty;
    logic [ENTRY_W-1:0] q_wdata;
    logic [ENTRY_W-1:0] q_rdata;

    // Predecode: the jump target is the low ADDR_W bits of imm26.
    assign is_j     = is_jump(imem_data);
    assign j_target = imem_data[ADDR_W-1:0];

    assign pop     = out_valid & out_ready;
    // A full queue still accepts a word when the head leaves this cycle.
    assign push_ok = !q_full | pop;
    assign push    = push_ok & !redirect_valid;
    assign q_wdata = {pc_q, imem_data, is_j};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (push_ok) begin
            // PC addition wraps naturally modulo 2^ADDR_W.
            pc_d = is_j ? j_target : pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A pop in a redirect cycle is still seen by decode; the flush discards
    // it here along with everything else.
    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop & !redirect_valid),
        .flush_i (redirect_valid),
        .wdata_i (q_wdata),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign imem_addr      = pc_q;
    assign out_valid      = !q_empty;
    assign out_pc         = out_valid ? q_rdata[ENTRY_W-1 -: ADDR_W] : '0;
    assign out_instr      = out_valid ? q_rdata[32:1] : '0;
    assign out_pred_taken = out_valid ? q_rdata[0] : 1'b0;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              out_pred_taken;

    // Second instance to exercise PC wrap from RESET_PC=1023 over an all-NOP ROM.
    logic [ADDR_W-1:0] w_imem_addr;
    logic [31:0]       w_imem_data;
    logic              w_out_valid;
    logic [31:0]       w_out_instr;
    logic [ADDR_W-1:0] w_out_pc;
    logic              w_out_pred_taken;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       instr;
        logic              taken;
    } exp_t;
    exp_t sb[$];

    localparam logic [31:0] W_ADDI1 = 32'h4021_0001; // ADDI r1,r1,1
    localparam logic [31:0] W_ADDI2 = 32'h4042_0002; // ADDI r2,r2,2
    localparam logic [31:0] W_J0    = 32'hA000_0000; // J 0

    function automatic logic [31:0] rom(input logic [ADDR_W-1:0] a);
        case (a)
            10'd0:   return W_ADDI1;
            10'd1:   return W_ADDI2;
            10'd2:   return W_J0;
            default: return 32'h0;
        endcase
    endfunction

    always_comb imem_data = rom(imem_addr);
    assign w_imem_data = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(ADDR_W), .QDEPTH(2), .RESET_PC(10'd0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pred_taken(out_pred_taken)
    );

    fetch_unit #(.ADDR_W(ADDR_W), .QDEPTH(2), .RESET_PC(10'd1023)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .redirect_valid(1'b0), .redirect_pc(10'd0),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_instr(w_out_instr),
        .out_pc(w_out_pc), .out_pred_taken(w_out_pred_taken)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected program order from start address s: the ROM loops 0,1,2 via J 0.
    task automatic sb_fill(input int s, input int n);
        sb.delete();
        for (int k = 0; k < n; k++) begin
            exp_t e;
            int p;
            p = (s + k) % 3;
            e.pc    = ADDR_W'(p);
            e.instr = rom(ADDR_W'(p));
            e.taken = (p == 2);
            sb.push_back(e);
        end
    endtask

    // Called just before an edge: if a handshake will happen, compare head to scoreboard.
    task automatic sb_observe();
        if (out_valid && out_ready) begin
            exp_t e;
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL sb_underflow observed=pop expected=none");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_pc", 64'(out_pc), 64'(e.pc));
                check("sb_instr", 64'(out_instr), 64'(e.instr));
                check("sb_taken", 64'(out_pred_taken), 64'(e.taken));
                $display("pop pc=%0d instr=%08h taken=%0b", out_pc, out_instr, out_pred_taken);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset state ----
        #12;
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_pred", 64'(out_pred_taken), 64'd0);
        check("rst_wrap_addr", 64'(w_imem_addr), 64'd1023);

        // ---- free run with out_ready=1 ----
        sb_fill(0, 20);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 9; c++) begin
            check("run_imem_addr", 64'(imem_addr), 64'(c % 3));
            if (c >= 1) check("run_valid", 64'(out_valid), 64'd1);
            if (c == 1) check("wrap_pc_1023", 64'(w_out_pc), 64'd1023);
            if (c == 2) check("wrap_pc_0", 64'(w_out_pc), 64'd0);
            sb_observe();
            step();
        end

        // ---- asynchronous reset mid-stream ----
        check("pre_areset_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", 64'(out_valid), 64'd0);
        check("areset_instr", 64'(out_instr), 64'd0);
        check("areset_pc", 64'(out_pc), 64'd0);
        check("areset_addr", 64'(imem_addr), 64'd0);

        // ---- backpressure from reset ----
        out_ready = 1'b0;
        sb_fill(0, 20);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) check("bp_restart_addr", 64'(imem_addr), 64'd0);
            if (c >= 2) check("bp_addr_hold", 64'(imem_addr), 64'd2);
            if (c >= 1) begin
                check("bp_pc_stable", 64'(out_pc), 64'd0);
                check("bp_instr_stable", 64'(out_instr), 64'(W_ADDI1));
            end
            step();
        end

        // ---- release: order resumes, full queue streams without a drop ----
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            check("stream_valid", 64'(out_valid), 64'd1);
            sb_observe();
            step();
        end

        // ---- redirect on a full queue ----
        out_ready = 1'b0;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 10'd1;
        step();
        redirect_valid = 1'b0;
        redirect_pc = 10'd0;
        check("redir_valid", 64'(out_valid), 64'd0);
        check("redir_instr_zero", 64'(out_instr), 64'd0);
        check("redir_addr", 64'(imem_addr), 64'd1);
        sb_fill(1, 20);
        out_ready = 1'b1;
        step();
        check("redir_head_pc", 64'(out_pc), 64'd1);
        check("redir_head_instr", 64'(out_instr), 64'(W_ADDI2));
        for (int c = 0; c < 6; c++) begin
            check("redir_stream_valid", 64'(out_valid), 64'd1);
            sb_observe();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_unit
